// File: rtl/game_tug_war.sv
// ---------------------------------------------------------------------------
// game_tug_war
//
// Two-player button-mash tug-of-war engine. Runs a countdown, then a play
// phase in which each player's button presses are counted, then a game-over
// screen. The press lead moves a rope position; the game ends when either
// player reaches TARGET presses or leads by MARGIN. Holding every button of
// both players on the game-over screen restarts the countdown.
//
// Ports
//   CLK         in   1       clock, rising edge
//   RESET       in   1       synchronous, active-high
//   ENABLE      in   1       game selected; low acts as RESET
//   P1_BTN      in   BTN_N   player-1 button levels (already synchronised)
//   P2_BTN      in   BTN_N   player-2 button levels (already synchronised)
//   SCREEN      out  3       one-hot: 001 countdown, 010 play, 100 game over
//   COUNT_DOWN  out  3       seconds left in countdown, 0 otherwise
//   P1_COUNT    out  CNT_W   player-1 press count
//   P2_COUNT    out  CNT_W   player-2 press count
//   LOCATION    out  LOC_W   rope position, 0 = player-2 end
//   WINNER      out  2       00 none, 01 P1, 10 P2, 11 draw
//
// SCREEN is the state register itself, so it doubles as the FSM state
// observation point. All outputs come straight from registers.
// ---------------------------------------------------------------------------
module game_tug_war #(
    parameter int CNT_W      = 7,
    parameter int TARGET     = 63,
    parameter int MARGIN     = 8,
    parameter int LOC_N      = 7,
    parameter int STEP       = 2,
    parameter int CD_SEC     = 3,
    parameter int SEC_CYCLES = 1000,
    parameter int BTN_N      = 2,
    localparam int LOC_W     = (LOC_N > 1) ? $clog2(LOC_N) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [BTN_N-1:0] P1_BTN,
    input  logic [BTN_N-1:0] P2_BTN,
    output logic [2:0]       SCREEN,
    output logic [2:0]       COUNT_DOWN,
    output logic [CNT_W-1:0] P1_COUNT,
    output logic [CNT_W-1:0] P2_COUNT,
    output logic [LOC_W-1:0] LOCATION,
    output logic [1:0]       WINNER
);

    // Screen / state encodings
    localparam logic [2:0] SCR_CD   = 3'b001;
    localparam logic [2:0] SCR_PLAY = 3'b010;
    localparam logic [2:0] SCR_OVER = 3'b100;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int CYC_W   = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam int CENTRE  = (LOC_N - 1) / 2;
    localparam int STEP_SH = (STEP > 1) ? $clog2(STEP) : 0;

    localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(SEC_CYCLES - 1);
    localparam logic [2:0]         CD_INIT   = 3'(CD_SEC);
    localparam logic [CNT_W-1:0]   TGT       = CNT_W'(TARGET);
    localparam logic [LOC_W-1:0]   LOC_C     = LOC_W'(CENTRE);
    localparam logic [LOC_W-1:0]   LOC_MAX   = LOC_W'(LOC_N - 1);
    localparam logic [CNT_W+1:0]   C_EXT     = (CNT_W+2)'(CENTRE);
    localparam logic [CNT_W+1:0]   STEP_RND  = (CNT_W+2)'(STEP - 1);
    localparam logic signed [CNT_W:0] MARGIN_POS = $signed((CNT_W+1)'(MARGIN));
    localparam logic signed [CNT_W:0] MARGIN_NEG = -MARGIN_POS;

    // Registers
    logic [2:0]       screen;
    logic [2:0]       count_down;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] p1_count;
    logic [CNT_W-1:0] p2_count;
    logic [LOC_W-1:0] location;
    logic [1:0]       winner;
    logic [BTN_N-1:0] p1_q;
    logic [BTN_N-1:0] p2_q;

    // Combinational helpers
    logic                    sync_rst;
    logic                    screen_legal;
    logic                    combo;
    logic                    go_home;
    logic                    p1_rise;
    logic                    p2_rise;
    logic                    hit_target;
    logic [1:0]              target_winner;
    logic [LOC_W-1:0]        target_loc;
    logic signed [CNT_W:0]   lead;
    logic [CNT_W:0]          lead_abs;
    logic [CNT_W+1:0]        steps;
    logic [LOC_W-1:0]        offset;
    logic [LOC_W-1:0]        rope_loc;

    assign sync_rst     = RESET | ~ENABLE;
    assign screen_legal = (screen == SCR_CD) || (screen == SCR_PLAY) ||
                          (screen == SCR_OVER);
    assign combo        = (&P1_BTN) & (&P2_BTN);

    // One condition covers reset, enable-low, illegal state recovery and
    // the game-over restart combo: all of them land in a fresh countdown.
    assign go_home = sync_rst | ~screen_legal | ((screen == SCR_OVER) & combo);

    // Any rising bit scores a single press for that player this cycle.
    assign p1_rise = |(P1_BTN & ~p1_q);
    assign p2_rise = |(P2_BTN & ~p2_q);

    // End-of-game decision works on the registered counts, so a press is
    // judged one edge after it is counted.
    assign hit_target = (p1_count == TGT) || (p2_count == TGT);

    always_comb begin
        target_winner = WIN_DRAW;
        target_loc    = LOC_C;
        if (p1_count > p2_count) begin
            target_winner = WIN_P1;
            target_loc    = LOC_MAX;
        end else if (p2_count > p1_count) begin
            target_winner = WIN_P2;
            target_loc    = '0;
        end
    end

    // Rope mapping: centre plus sign(lead) * ceil(|lead| / STEP), clamped.
    assign lead     = $signed({1'b0, p1_count}) - $signed({1'b0, p2_count});
    assign lead_abs = lead[CNT_W] ? $unsigned(-lead) : $unsigned(lead);
    assign steps    = ({1'b0, lead_abs} + STEP_RND) >> STEP_SH;

    always_comb begin
        offset = LOC_C;
        if (steps <= C_EXT) begin
            offset = steps[LOC_W-1:0];
        end
    end

    assign rope_loc = lead[CNT_W] ? (LOC_C - offset) : (LOC_C + offset);

    always_ff @(posedge CLK) begin
        // Button history follows the inputs in every state, including reset,
        // so buttons held across a reset or restart never count as a press.
        p1_q <= P1_BTN;
        p2_q <= P2_BTN;

        if (go_home) begin
            screen     <= SCR_CD;
            count_down <= CD_INIT;
            cyc_cnt    <= '0;
            p1_count   <= '0;
            p2_count   <= '0;
            location   <= LOC_C;
            winner     <= WIN_NONE;
        end else begin
            case (screen)
                SCR_CD: begin
                    p1_count <= '0;
                    p2_count <= '0;
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (count_down <= 3'd1) begin
                            screen     <= SCR_PLAY;
                            count_down <= 3'd0;
                        end else begin
                            count_down <= count_down - 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                SCR_PLAY: begin
                    count_down <= 3'd0;
                    // Counts freeze on the edge that ends the game so the
                    // final score is the one the decision was made on.
                    if (hit_target) begin
                        screen   <= SCR_OVER;
                        winner   <= target_winner;
                        location <= target_loc;
                    end else if (lead >= MARGIN_POS) begin
                        screen   <= SCR_OVER;
                        winner   <= WIN_P1;
                        location <= LOC_MAX;
                    end else if (lead <= MARGIN_NEG) begin
                        screen   <= SCR_OVER;
                        winner   <= WIN_P2;
                        location <= '0;
                    end else begin
                        location <= rope_loc;
                        if (p1_rise && (p1_count != TGT)) begin
                            p1_count <= p1_count + 1'b1;
                        end
                        if (p2_rise && (p2_count != TGT)) begin
                            p2_count <= p2_count + 1'b1;
                        end
                    end
                end

                default: begin
                    // Game over: everything frozen until the restart combo.
                end
            endcase
        end
    end

    assign SCREEN     = screen;
    assign COUNT_DOWN = count_down;
    assign P1_COUNT   = p1_count;
    assign P2_COUNT   = p2_count;
    assign LOCATION   = location;
    assign WINNER     = winner;

endmodule

// File: tb/tb_game_tug_war.sv
// ---------------------------------------------------------------------------
// tb_game_tug_war
//
// Directed bench for game_tug_war with default parameters. Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at the same point,
// well away from the active edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_game_tug_war;

    localparam int CNT_W = 7;
    localparam int LOC_W = 3;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       p1_btn;
    logic [1:0]       p2_btn;
    logic [2:0]       screen;
    logic [2:0]       count_down;
    logic [CNT_W-1:0] p1_count;
    logic [CNT_W-1:0] p2_count;
    logic [LOC_W-1:0] location;
    logic [1:0]       winner;

    int checks   = 0;
    int failures = 0;

    game_tug_war dut (
        .CLK        (clk),
        .RESET      (reset),
        .ENABLE     (enable),
        .P1_BTN     (p1_btn),
        .P2_BTN     (p2_btn),
        .SCREEN     (screen),
        .COUNT_DOWN (count_down),
        .P1_COUNT   (p1_count),
        .P2_COUNT   (p2_count),
        .LOCATION   (location),
        .WINNER     (winner)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // One press: buttons up for one edge, then all released for one edge.
    task automatic press(input logic [1:0] m1, input logic [1:0] m2);
        p1_btn = m1;
        p2_btn = m2;
        tick();
        p1_btn = 2'b00;
        p2_btn = 2'b00;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_scr,
                             input logic [2:0] e_cd, input int e_p1,
                             input int e_p2, input int e_loc,
                             input logic [1:0] e_win);
        check({tag, ".screen"},     32'(screen),     32'(e_scr));
        check({tag, ".count_down"}, 32'(count_down), 32'(e_cd));
        check({tag, ".p1_count"},   32'(p1_count),   e_p1);
        check({tag, ".p2_count"},   32'(p2_count),   e_p2);
        check({tag, ".location"},   32'(location),   e_loc);
        check({tag, ".winner"},     32'(winner),     32'(e_win));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        p1_btn = 2'b00;
        p2_btn = 2'b00;
        ticks(2);
        check_all("reset", 3'b001, 3'd3, 0, 0, 3, 2'b00);

        // Countdown: 999 edges after release still show 3, with P1 mashing.
        reset = 1'b0;
        for (int i = 0; i < 999; i++) begin
            p1_btn = {1'b0, i[0]};
            tick();
        end
        p1_btn = 2'b00;
        check_all("cd_3_end", 3'b001, 3'd3, 0, 0, 3, 2'b00);
        tick();
        check("cd_2_start", 32'(count_down), 32'd2);
        ticks(999);
        check("cd_2_end", 32'(count_down), 32'd2);
        tick();
        check("cd_1_start", 32'(count_down), 32'd1);
        ticks(999);
        check_all("cd_1_end", 3'b001, 3'd1, 0, 0, 3, 2'b00);
        tick();
        check_all("play_entry", 3'b010, 3'd0, 0, 0, 3, 2'b00);

        // P1 x5, P2 x2: lead 3 -> 3 + ceil(3/2) = 5
        for (int i = 0; i < 5; i++) press(2'b01, 2'b00);
        for (int i = 0; i < 2; i++) press(2'b00, 2'b10);
        check_all("lead_p3", 3'b010, 3'd0, 5, 2, 5, 2'b00);

        // P2 x4 more: lead -1 -> 3 - 1 = 2
        for (int i = 0; i < 4; i++) press(2'b00, 2'b01);
        check_all("lead_m1", 3'b010, 3'd0, 5, 6, 2, 2'b00);

        // Build 10/7 (lead 3 -> location 5), then drop ENABLE.
        for (int i = 0; i < 5; i++) press(2'b10, 2'b00);
        press(2'b00, 2'b10);
        check_all("pre_enable_drop", 3'b010, 3'd0, 10, 7, 5, 2'b00);
        enable = 1'b0;
        tick();
        check_all("enable_drop", 3'b001, 3'd3, 0, 0, 3, 2'b00);
        enable = 1'b1;

        // Fresh countdown of 3000 edges.
        ticks(2999);
        check("cd_again_end", 32'(screen), 32'b001);
        tick();
        check("play_again", 32'(screen), 32'b010);

        // P1 alone to 8: margin win.
        for (int i = 0; i < 7; i++) press(2'b01, 2'b00);
        check_all("p1_lead7", 3'b010, 3'd0, 7, 0, 6, 2'b00);
        p1_btn = 2'b01;
        tick();
        check("p1_8th_count", 32'(p1_count), 32'd8);
        check("p1_8th_screen", 32'(screen), 32'b010);
        p1_btn = 2'b00;
        tick();
        check_all("p1_margin_win", 3'b100, 3'd0, 8, 0, 6, 2'b01);
        press(2'b01, 2'b00);
        press(2'b10, 2'b01);
        check_all("over_frozen", 3'b100, 3'd0, 8, 0, 6, 2'b01);

        // Restart combo, held through the whole countdown.
        p1_btn = 2'b11;
        p2_btn = 2'b11;
        tick();
        check_all("restart", 3'b001, 3'd3, 0, 0, 3, 2'b00);
        ticks(2999);
        check("restart_cd_end", 32'(screen), 32'b001);
        tick();
        check_all("restart_play", 3'b010, 3'd0, 0, 0, 3, 2'b00);
        ticks(3);
        check_all("held_no_press", 3'b010, 3'd0, 0, 0, 3, 2'b00);
        p1_btn = 2'b00;
        p2_btn = 2'b00;
        tick();
        check("release_no_press", 32'(p1_count), 32'd0);
        for (int i = 0; i < 3; i++) press(2'b01, 2'b00);
        for (int i = 0; i < 2; i++) press(2'b00, 2'b01);
        check_all("repress", 3'b010, 3'd0, 3, 2, 4, 2'b00);

        // RESET mid-play.
        reset = 1'b1;
        tick();
        check_all("reset_mid_play", 3'b001, 3'd3, 0, 0, 3, 2'b00);
        reset = 1'b0;
        ticks(3000);
        check("play_third", 32'(screen), 32'b010);

        // Alternating presses to 62/62, then a simultaneous double-bit rise.
        press(2'b01, 2'b00);
        check("alt_lead1_loc", 32'(location), 32'd4);
        press(2'b00, 2'b01);
        for (int i = 0; i < 61; i++) begin
            press(2'b01, 2'b00);
            press(2'b00, 2'b01);
        end
        check_all("alt_62", 3'b010, 3'd0, 62, 62, 3, 2'b00);
        p1_btn = 2'b11;
        p2_btn = 2'b11;
        tick();
        check_all("both_63", 3'b010, 3'd0, 63, 63, 3, 2'b00);
        p1_btn = 2'b00;
        p2_btn = 2'b00;
        tick();
        check_all("draw", 3'b100, 3'd0, 63, 63, 3, 2'b11);
        press(2'b01, 2'b10);
        check_all("draw_frozen", 3'b100, 3'd0, 63, 63, 3, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
